// File: rtl/if_prefetch_buffer_if.sv
// Instruction-memory request channel plus the IF/ID head-of-queue signals
// for if_prefetch_buffer.
interface if_prefetch_buffer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] flush_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_instr;
  logic             ready;

  // Fetch unit side
  modport master (
    input  stall, flush, flush_pc, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_pc, if_instr, ready
  );

  // Memory / decode side
  modport slave (
    output stall, flush, flush_pc, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_pc, if_instr, ready
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: pipelined in-order imem fetches into a {pc,instr} FIFO feeding IF/ID.
// Optional IF_BYPASS_EN presents a returning word combinationally when the FIFO is empty.
module if_prefetch_buffer #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      MAX_OUTST = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input logic                  clk,
  input logic                  rst,
  if_prefetch_buffer_if.master bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] last_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [OUT_W-1:0] outst, drop;
  logic [PTR_W-1:0] tag_rd, tag_wr;
  logic [WIDTH-1:0] fifo_pc    [DEPTH];
  logic [WIDTH-1:0] fifo_instr [DEPTH];
  logic [WIDTH-1:0] tag_q      [DEPTH];

  logic             rvalid_ok, keep, issue, handshake, fifo_ready, bypass_hit, push, pop;
  logic [WIDTH-1:0] tag;

  assign tag = tag_q[tag_rd];

  // Issue reserves FIFO space for every outstanding request, so push never overflows
  always_comb begin
    rvalid_ok  = bus.imem_rvalid && (outst != '0);
    keep       = rvalid_ok && (drop == '0) && !bus.flush;
    issue      = rst && !bus.flush
                 && ((SUM_W'(count) + SUM_W'(outst)) < SUM_W'(DEPTH))
                 && (outst < OUT_W'(MAX_OUTST));
    handshake  = issue && bus.imem_gnt;
    fifo_ready = (count != '0);
`ifdef IF_BYPASS_EN
    bypass_hit = keep && !fifo_ready;
`else
    bypass_hit = 1'b0;
`endif
    push       = keep && !(bypass_hit && !bus.stall);
    pop        = fifo_ready && !bus.stall && !bus.flush;
  end

  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc;
    bus.ready     = fifo_ready || bypass_hit;
    bus.if_pc     = last_pc;
    bus.if_instr  = NOP;
    if (fifo_ready) begin
      bus.if_pc    = fifo_pc[rd_ptr];
      bus.if_instr = fifo_instr[rd_ptr];
    end else if (bypass_hit) begin
      bus.if_pc    = tag;
      bus.if_instr = bus.imem_rdata;
    end
  end

  // Control state; flush kills the FIFO and marks every in-flight word for discard
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      last_pc  <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      outst    <= '0;
      drop     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      if (bus.flush)      fetch_pc <= bus.flush_pc & ~WIDTH'(3);
      else if (handshake) fetch_pc <= fetch_pc + WIDTH'(4);

      if (handshake && !rvalid_ok)      outst <= outst + OUT_W'(1);
      else if (!handshake && rvalid_ok) outst <= outst - OUT_W'(1);

      if (handshake) tag_wr <= tag_wr + PTR_W'(1);
      if (rvalid_ok) tag_rd <= tag_rd + PTR_W'(1);

      if (bus.flush)                    drop <= outst - OUT_W'(rvalid_ok);
      else if (rvalid_ok && drop != '0) drop <= drop - OUT_W'(1);

      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (pop)                             last_pc <= fifo_pc[rd_ptr];
      else if (bypass_hit && !bus.stall)   last_pc <= tag;
    end
  end

  // Storage arrays need no reset; validity lives in the pointers and counters
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= tag;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
    if (handshake) tag_q[tag_wr] <= fetch_pc;
  end

  a_rvalid_has_outst: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rvalid && outst == '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based fetch model.
module tb_if_prefetch_buffer;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;
`ifdef IF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam int LAT    = 1;
`else
  localparam bit BYPASS = 1'b0;
  localparam int LAT    = 2;
`endif

  logic clk = 1'b0;
  logic rst;

  if_prefetch_buffer_if #(.WIDTH(WIDTH)) bus ();

  if_prefetch_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory content: distinct per address, 0x400 holds 32'h00500093
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h0050_0493;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference model: in-flight request list (with stale marks) and a FIFO of presented words
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  fl_t         inflight[$];
  ent_t        fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_last_pc;
  bit          model_valid = 1'b0;

  always @(negedge clk) begin : compare
    int unsigned outst;
    bit          exp_req, rv_ok, live, byp, do_pop;
    bit          exp_ready;
    logic [31:0] exp_pc, exp_instr;
    fl_t         head;
    cyc++;
    outst   = inflight.size();
    exp_req = rst && !bus.flush && (fifo.size() + outst < DEPTH) && (outst < MAX_OUTST);
    rv_ok   = bus.imem_rvalid && (outst > 0);
    live    = rv_ok && !bus.flush && !inflight[0].stale;
    byp     = BYPASS && (fifo.size() == 0) && live;
    if (fifo.size() != 0) begin
      exp_ready = 1'b1; exp_pc = fifo[0].pc; exp_instr = fifo[0].instr;
    end else if (byp) begin
      exp_ready = 1'b1; exp_pc = inflight[0].pc; exp_instr = instr_of(inflight[0].pc);
    end else begin
      exp_ready = 1'b0; exp_pc = m_last_pc; exp_instr = NOP;
    end

    if (model_valid) begin
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", bus.imem_addr, m_fetch_pc);
      check("ready", 32'(bus.ready), 32'(exp_ready));
      check("if_pc", bus.if_pc, exp_pc);
      check("if_instr", bus.if_instr, exp_instr);
    end

    if (!rst) begin
      inflight.delete();
      fifo.delete();
      m_fetch_pc  = 32'h0;
      m_last_pc   = 32'h0;
      model_valid = 1'b1;
    end else begin
      do_pop = (fifo.size() != 0) && !bus.stall && !bus.flush;
      if (rv_ok) head = inflight.pop_front();
      if (bus.flush) begin
        fifo.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_fetch_pc = {bus.flush_pc[31:2], 2'b00};
      end else begin
        if (do_pop) begin
          m_last_pc = fifo[0].pc;
          void'(fifo.pop_front());
        end
        if (live) begin
          if (byp && !bus.stall) m_last_pc = head.pc;
          else fifo.push_back('{head.pc, instr_of(head.pc)});
        end
        if (exp_req && bus.imem_gnt) begin
          inflight.push_back('{m_fetch_pc, 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  end

  // Memory responder: returns accepted addresses in order, at least one cycle later
  logic [31:0] mem_q[$];

  task automatic drive(input bit r, input bit g, input bit st, input bit fl,
                       input logic [31:0] fpc, input int unsigned rv_pct);
    @(posedge clk);
    #1;
    rst          = r;
    bus.imem_gnt = g;
    bus.stall    = st;
    bus.flush    = fl;
    bus.flush_pc = fpc;
    if (!r) mem_q.delete();
    if (r && mem_q.size() != 0 && $urandom_range(99) < rv_pct) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = instr_of(mem_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
    end
    @(negedge clk);
    if (bus.imem_req && bus.imem_gnt) mem_q.push_back(bus.imem_addr);
  endtask

  initial begin
    bit          got;
    int          rv_k, rdy_k;
    bit          r_r, r_fl;
    logic [31:0] r_fpc;
    rst = 1'b0;
    bus.imem_gnt = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

    drive(0, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_instr", bus.if_instr, NOP);

    // Streaming from reset
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 0, 32'h0, 100);
      if (k == 0) begin
        check("t1_req0", 32'(bus.imem_req), 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        check("t1_ready0", 32'(bus.ready), 32'd0);
      end
      if (k == 1) check("t1_addr1", bus.imem_addr, 32'h4);
      if (k >= LAT) check("t1_stream_pc", bus.if_pc, 32'(4 * (k - LAT)));
    end

    // Stall fills the FIFO, then release drains it in consecutive pops
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, 0, 32'h0, 100);
      check("t2_hold_pc", bus.if_pc, 32'(4 * (10 - LAT)));
      check("t2_hold_ready", 32'(bus.ready), 32'd1);
    end
    check("t2_req_low", 32'(bus.imem_req), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, 0, 32'h0, 100);
      check("t2_pop_pc", bus.if_pc, 32'(4 * (10 - LAT + k)));
    end
    repeat (4) drive(1, 1, 0, 0, 32'h0, 100);

    // Flush with two requests in flight
    drive(1, 1, 0, 0, 32'h0, 0);
    drive(1, 1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 1, 32'h100, 0);
    drive(1, 1, 0, 0, 32'h0, 100);
    check("t3_ready_after_flush", 32'(bus.ready), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      drive(1, 1, 0, 0, 32'h0, 100);
      if (bus.ready) got = 1'b1;
    end
    check("t3_ready_seen", 32'(got), 32'd1);
    check("t3_first_pc", bus.if_pc, 32'h100);
    drive(1, 1, 0, 0, 32'h0, 100);
    check("t3_second_pc", bus.if_pc, 32'h104);

    // Redirect alignment and address wrap
    drive(1, 1, 0, 1, 32'h202, 100);
    drive(1, 1, 0, 0, 32'h0, 100);
    check("t4_align", bus.imem_addr, 32'h200);
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 100);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      drive(1, 1, 0, 0, 32'h0, 100);
      if (bus.imem_req) got = 1'b1;
    end
    check("t4_req_seen", 32'(got), 32'd1);
    check("t4_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 32'h0, 100);
    check("t4_wrap", bus.imem_addr, 32'h0);

    // Grant withheld: request and address hold, nothing presented
    drive(1, 0, 0, 1, 32'h300, 100);
    repeat (3) drive(1, 0, 0, 0, 32'h0, 100);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 32'h0, 100);
      check("t5_req_hold", 32'(bus.imem_req), 32'd1);
      check("t5_addr_hold", bus.imem_addr, 32'h300);
      check("t5_ready", 32'(bus.ready), 32'd0);
      check("t5_nop", bus.if_instr, NOP);
    end

    // Response-to-ready latency on an empty FIFO
    drive(1, 1, 0, 1, 32'h400, 100);
    got = 1'b0; rv_k = -100; rdy_k = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      drive(1, 1, 0, 0, 32'h0, 100);
      if (bus.imem_rvalid && bus.imem_rdata == 32'h0050_0093 && rv_k < 0) rv_k = k;
      if (bus.ready) begin
        got   = 1'b1;
        rdy_k = k;
      end
    end
    check("t6_ready_seen", 32'(got), 32'd1);
    check("t6_instr", bus.if_instr, 32'h0050_0093);
    check("t6_pc", bus.if_pc, 32'h400);
    check("t6_latency", 32'(rdy_k - rv_k), 32'(LAT - 1));

    // Randomized traffic with stalls, flushes and occasional mid-run resets
    for (int k = 0; k < 3000; k++) begin
      r_r   = ($urandom_range(999) >= 4);
      r_fl  = ($urandom_range(99) < 4);
      r_fpc = $urandom();
      if ($urandom_range(7) == 0) r_fpc = 32'hFFFF_FFF0 | (r_fpc & 32'hF);
      drive(r_r, $urandom_range(99) < 70, $urandom_range(99) < 30, r_fl, r_fpc,
            $urandom_range(100, 20));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
